// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default bit timing.
// PARITY_BIT state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 21810;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA_BITS,
`ifdef UART_TX_PARITY_EN
    ST_PARITY_BIT,
`endif
    ST_STOP_BIT
  } TxState;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte write channel into the transmitter: a single-cycle strobe with no backpressure.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;

  modport master (output i_data, output i_valid);
  modport slave  (input  i_data, input  i_valid);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO succeeds only alongside a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign o_empty    = (count == '0);
  assign o_full     = (count == (AW+1)'(DEPTH));
  assign do_pop     = i_pop && !o_empty;
  assign do_push    = i_push && (!o_full || do_pop);
  assign o_pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with an input FIFO and a sticky overflow flag.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     i_reset_n,
  uart_tx_if.slave wr,
  output logic     o_tx,
  output logic     o_busy,
  output logic     o_fifo_full,
  output logic     o_overflow
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  TxState               state, state_nxt;
  logic [CW-1:0]        cyc_cnt, cyc_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_reg, tx_nxt;
  logic                 overflow;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_nxt;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_push      (wr.i_valid),
    .i_push_data (wr.i_data),
    .i_pop       (fifo_pop),
    .o_pop_data  (fifo_data),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  assign bit_done    = (cyc_cnt == CYC_LAST);
  assign o_tx        = tx_reg;
  assign o_busy      = (state != ST_IDLE) || !fifo_empty;
  assign o_fifo_full = fifo_full;
  assign o_overflow  = overflow;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_reg   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx_reg  <= tx_nxt;
      if (wr.i_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) parity <= 1'b0;
    else            parity <= parity_nxt;
  end
`endif

  // The line value for the next cycle is decided together with the state change.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx_reg;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt = parity;
`endif
    case (state)
      ST_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_data;
          state_nxt = ST_START_BIT;
          tx_nxt    = 1'b0;
          cyc_nxt   = '0;
`ifdef UART_TX_PARITY_EN
          parity_nxt = ^fifo_data;
`endif
        end
      end
      ST_START_BIT: begin
        if (bit_done) begin
          state_nxt = ST_DATA_BITS;
          tx_nxt    = shift[0];
          bit_nxt   = '0;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CW'(1);
        end
      end
      ST_DATA_BITS: begin
        if (bit_done) begin
          cyc_nxt = '0;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY_BIT;
            tx_nxt    = parity;
`else
            state_nxt = ST_STOP_BIT;
            tx_nxt    = 1'b1;
`endif
          end else begin
            shift_nxt = shift >> 1;
            bit_nxt   = bit_idx + BW'(1);
            tx_nxt    = shift[1];
          end
        end else begin
          cyc_nxt = cyc_cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY_BIT: begin
        if (bit_done) begin
          state_nxt = ST_STOP_BIT;
          tx_nxt    = 1'b1;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + CW'(1);
        end
      end
`endif
      ST_STOP_BIT: begin
        if (bit_done) begin
          cyc_nxt = '0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_nxt = fifo_data;
            state_nxt = ST_START_BIT;
            tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_nxt = ^fifo_data;
`endif
          end else begin
            state_nxt = ST_IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          cyc_nxt = cyc_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
        cyc_nxt   = '0;
      end
    endcase
  end

endmodule
